wb_forward_unit: RTL



---
 rtl/riscv_pipe_pkg.sv | 43 ++++
 rtl/fwd_select.sv | 59 +++++
 rtl/wb_forward_unit.sv | 86 ++++++++
 3 files changed

// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared types and helpers for the MEM/WB back end and operand forwarding
package riscv_pipe_pkg;

    localparam int PIPE_XLEN   = 32;
    localparam int PIPE_REG_AW = 5;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_MEM,
        FWD_WB
    } fwd_sel_e;

    typedef struct packed {
        logic                   valid;
        logic                   reg_write;
        logic [PIPE_REG_AW-1:0] rd;
        wb_sel_e                wb_sel;
        logic [PIPE_XLEN-1:0]   alu_result;
        logic [PIPE_XLEN-1:0]   pc_plus4;
    } pipe_wb_t;

    localparam logic [PIPE_REG_AW-1:0] REG_X0 = '0;

    // The reserved encoding 2'b11 is folded into WB_ALU at capture time.
    function automatic wb_sel_e decode_wb_sel(input logic [1:0] sel);
        case (sel)
            2'b01:   return WB_MEM;
            2'b10:   return WB_PC4;
            default: return WB_ALU;
        endcase
    endfunction

    function automatic logic stage_writes(input pipe_wb_t s);
        return s.valid & s.reg_write & (s.rd != REG_X0);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - per-operand forwarding priority selector and hazard detect (FWD_PATHS_EN)
module fwd_select
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN   = PIPE_XLEN,
    parameter int REG_AW = PIPE_REG_AW
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   rdata,
    input  pipe_wb_t          mem_stage,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_wdata,
    output logic [XLEN-1:0]   fwd_rdata,
    output logic              hazard
);

    fwd_sel_e sel;
    logic     mem_hit;
    logic     wb_hit;

    assign mem_hit = stage_writes(mem_stage) && (mem_stage.rd == rs);
    assign wb_hit  = wb_we && (wb_rd == rs) && (rs != REG_X0);

`ifdef FWD_PATHS_EN
    // Load data only exists in WB, so a MEM-stage load must stall instead of forward.
    assign hazard = mem_hit && (mem_stage.wb_sel == WB_MEM);

    always_comb begin
        sel = FWD_RF;
        if (mem_hit && (mem_stage.wb_sel != WB_MEM)) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end
`else
    logic unused_fwd_data;

    // Without bypass paths the consumer waits until the producer has left WB.
    assign hazard = mem_hit || wb_hit;
    assign unused_fwd_data = ^{wb_wdata, mem_stage.alu_result, mem_stage.pc_plus4, mem_stage.wb_sel};

    always_comb begin
        sel = FWD_RF;
    end
`endif

    always_comb begin
        fwd_rdata = rdata;
        case (sel)
            FWD_MEM: fwd_rdata = (mem_stage.wb_sel == WB_PC4) ? mem_stage.pc_plus4
                                                              : mem_stage.alu_result;
            FWD_WB:  fwd_rdata = wb_wdata;
            default: fwd_rdata = rdata;
        endcase
    end

endmodule

// File: rtl/wb_forward_unit.sv
// rtl/wb_forward_unit.sv - MEM/WB pipeline registers, register-file write port, forwarding and stall (FWD_PATHS_EN)
module wb_forward_unit
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN   = PIPE_XLEN,
    parameter int REG_AW = PIPE_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [1:0]        ex_wb_sel,
    input  logic [XLEN-1:0]   ex_alu_result,
    input  logic [XLEN-1:0]   ex_pc_plus4,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [XLEN-1:0]   rdata1,
    input  logic [XLEN-1:0]   rdata2,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              flush,
    output logic [XLEN-1:0]   fwd_rdata1,
    output logic [XLEN-1:0]   fwd_rdata2,
    output logic              stall,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_wdata
);

    pipe_wb_t mem_q;
    pipe_wb_t wb_q;
    logic     hazard1;
    logic     hazard2;

    // A stalled or flushed EX instruction enters MEM as a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            mem_q.valid      <= ex_valid & ~flush & ~stall;
            mem_q.reg_write  <= ex_reg_write;
            mem_q.rd         <= ex_rd;
            mem_q.wb_sel     <= decode_wb_sel(ex_wb_sel);
            mem_q.alu_result <= ex_alu_result;
            mem_q.pc_plus4   <= ex_pc_plus4;
            wb_q             <= mem_q;
        end
    end

    always_comb begin
        wb_wdata = wb_q.alu_result;
        case (wb_q.wb_sel)
            WB_MEM:  wb_wdata = mem_rdata;
            WB_PC4:  wb_wdata = wb_q.pc_plus4;
            default: wb_wdata = wb_q.alu_result;
        endcase
    end

    assign wb_we = stage_writes(wb_q);
    assign wb_rd = wb_q.rd;
    assign stall = hazard1 | hazard2;

    fwd_select #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd1 (
        .rs        (ex_rs1),
        .rdata     (rdata1),
        .mem_stage (mem_q),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_wdata  (wb_wdata),
        .fwd_rdata (fwd_rdata1),
        .hazard    (hazard1)
    );

    fwd_select #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd2 (
        .rs        (ex_rs2),
        .rdata     (rdata2),
        .mem_stage (mem_q),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_wdata  (wb_wdata),
        .fwd_rdata (fwd_rdata2),
        .hazard    (hazard2)
    );

endmodule
